// File: rtl/xm_mem_stage.sv
// Memory stage of the 5-stage pipeline: latches execute results, runs the
// request/done handshake with data memory and feeds the MEM/WB register.
module xm_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_XM,
  input  logic [15:0] alu_data_XM,
  input  logic [15:0] wr_data_XM,
  input  logic        memRead_XM,
  input  logic        memWrite_XM,
  input  logic        memToReg_XM,
  input  logic        regWrite_XM,
  input  logic [2:0]  writeReg_XM,
  input  logic        halt_XM,
  output logic        stall_XM,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        valid_MW,
  output logic [15:0] wb_data_MW,
  output logic [2:0]  writeReg_MW,
  output logic        regWrite_MW,
  output logic        halt_MW,
  output logic        err_MW
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  cnt_r;

  logic        x_valid_r;
  logic [15:0] x_alu_r;
  logic [15:0] x_wdata_r;
  logic        x_read_r;
  logic        x_write_r;
  logic        x_mtr_r;
  logic        x_rw_r;
  logic [2:0]  x_wreg_r;
  logic        x_halt_r;

  logic        x_load_s;
  logic        in_mem_ok_s;
  logic        x_misalign_s;
  logic        timeout_s;

  logic        mw_valid_s;
  logic [15:0] mw_wb_s;
  logic [2:0]  mw_wreg_s;
  logic        mw_rw_s;
  logic        mw_halt_s;
  logic        mw_err_s;

  function automatic logic is_mem(input logic rd, input logic wr);
    return rd | wr;
  endfunction

  // Qualifiers shared by the state, latch and MW logic.
  always_comb begin
    x_load_s     = ~stall_XM & (state_r != ST_HALTED);
    in_mem_ok_s  = valid_XM & is_mem(memRead_XM, memWrite_XM) & ~alu_data_XM[0];
    x_misalign_s = x_valid_r & is_mem(x_read_r, x_write_r) & x_alu_r[0];
    timeout_s    = (state_r == ST_REQ) & ~mem_done & (cnt_r == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; an aligned memory op enters REQ on the edge it is latched.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (x_valid_r & (x_halt_r | x_misalign_s)) begin
          state_s = ST_HALTED;
        end else if (in_mem_ok_s) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_done) begin
          if (x_halt_r) begin
            state_s = ST_HALTED;
          end else if (in_mem_ok_s) begin
            state_s = ST_REQ;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (timeout_s) begin
          state_s = ST_HALTED;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_HALTED: state_s = ST_HALTED;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Memory interface and stall decode from registered state and latch.
  always_comb begin
    stall_XM  = 1'b0;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    case (state_r)
      ST_REQ: begin
        stall_XM  = ~mem_done;
        mem_req   = 1'b1;
        mem_wr    = x_write_r;
        mem_addr  = x_alu_r;
        mem_wdata = x_wdata_r;
      end
      ST_HALTED: stall_XM = 1'b1;
      default:   stall_XM = 1'b0;
    endcase
  end

  // Cycles spent waiting in REQ; zero whenever a new request starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 8'd0;
    end else if ((state_r == ST_REQ) && !mem_done) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= 8'd0;
    end
  end

  // Execute-result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_valid_r <= 1'b0;
      x_alu_r   <= 16'h0000;
      x_wdata_r <= 16'h0000;
      x_read_r  <= 1'b0;
      x_write_r <= 1'b0;
      x_mtr_r   <= 1'b0;
      x_rw_r    <= 1'b0;
      x_wreg_r  <= 3'd0;
      x_halt_r  <= 1'b0;
    end else if (x_load_s) begin
      x_valid_r <= valid_XM;
      x_alu_r   <= alu_data_XM;
      x_wdata_r <= wr_data_XM;
      x_read_r  <= memRead_XM;
      x_write_r <= memWrite_XM;
      x_mtr_r   <= memToReg_XM;
      x_rw_r    <= regWrite_XM;
      x_wreg_r  <= writeReg_XM;
      x_halt_r  <= halt_XM;
    end else begin
      x_valid_r <= x_valid_r;
    end
  end

  // MEM/WB next value; waiting REQ cycles send a bubble downstream.
  always_comb begin
    mw_valid_s = valid_MW;
    mw_wb_s    = wb_data_MW;
    mw_wreg_s  = writeReg_MW;
    mw_rw_s    = regWrite_MW;
    mw_halt_s  = halt_MW;
    mw_err_s   = err_MW;
    case (state_r)
      ST_IDLE: begin
        mw_valid_s = x_valid_r;
        mw_wb_s    = x_alu_r;
        mw_wreg_s  = x_wreg_r;
        mw_rw_s    = x_valid_r & x_rw_r & ~x_misalign_s;
        mw_halt_s  = x_valid_r & (x_halt_r | x_misalign_s);
        mw_err_s   = x_misalign_s;
      end
      ST_REQ: begin
        if (mem_done) begin
          mw_valid_s = 1'b1;
          mw_wb_s    = x_mtr_r ? mem_rdata : x_alu_r;
          mw_wreg_s  = x_wreg_r;
          mw_rw_s    = x_rw_r;
          mw_halt_s  = x_halt_r;
          mw_err_s   = 1'b0;
        end else if (timeout_s) begin
          mw_valid_s = 1'b1;
          mw_wb_s    = x_alu_r;
          mw_wreg_s  = x_wreg_r;
          mw_rw_s    = 1'b0;
          mw_halt_s  = 1'b1;
          mw_err_s   = 1'b1;
        end else begin
          mw_valid_s = 1'b0;
          mw_rw_s    = 1'b0;
          mw_halt_s  = 1'b0;
          mw_err_s   = 1'b0;
        end
      end
      ST_HALTED: mw_valid_s = 1'b0;
      default: begin
        mw_valid_s = 1'b0;
        mw_rw_s    = 1'b0;
      end
    endcase
  end

  // MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_MW    <= 1'b0;
      wb_data_MW  <= 16'h0000;
      writeReg_MW <= 3'd0;
      regWrite_MW <= 1'b0;
      halt_MW     <= 1'b0;
      err_MW      <= 1'b0;
    end else begin
      valid_MW    <= mw_valid_s;
      wb_data_MW  <= mw_wb_s;
      writeReg_MW <= mw_wreg_s;
      regWrite_MW <= mw_rw_s;
      halt_MW     <= mw_halt_s;
      err_MW      <= mw_err_s;
    end
  end

endmodule
